// File: rtl/lsu.sv
// ---------------------------------------------------------------------------
// lsu: load/store unit sitting after the execute-stage ALU.
//
// Takes ALUout as the effective address and rs2 (WriteData) as the store
// data. It runs a req/gnt/rvalid handshake with data memory, steers store
// bytes onto the correct lanes, and extracts and extends load data.
//
// Ports
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   req_valid       execute stage presents a memory op this cycle
//   req_ready       LSU is idle and can accept an op
//   MemWrite        1 = store, 0 = load
//   funct3          RV32I width/sign code
//   ALUout          effective address
//   WriteData       rs2 store data
//   mem_req/gnt     memory request, held until granted
//   mem_addr        word-aligned address
//   mem_we          write enable
//   mem_wstrb       byte-lane strobes
//   mem_wdata       lane-replicated store data
//   mem_rvalid      load data valid
//   mem_rdata       load word
//   ReadData        extended load result, held until the next load completes
//   rsp_valid       one-cycle completion pulse
//   Stall           freeze upstream pipeline
//   misalign_fault  (only with LSU_MISALIGN_TRAP_EN) misaligned-op pulse
//
// Optional build macro: LSU_MISALIGN_TRAP_EN. When it is defined, a misaligned
// halfword or word op completes at once with misalign_fault and never touches
// memory. When it is undefined, the low address bits below the access size
// are ignored.
// ---------------------------------------------------------------------------
module lsu #(
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  MemWrite,
    input  logic [2:0]            funct3,
    input  logic [ADDR_WIDTH-1:0] ALUout,
    input  logic [31:0]           WriteData,
    output logic                  mem_req,
    input  logic                  mem_gnt,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [3:0]            mem_wstrb,
    output logic [31:0]           mem_wdata,
    input  logic                  mem_rvalid,
    input  logic [31:0]           mem_rdata,
    output logic [31:0]           ReadData,
    output logic                  rsp_valid,
`ifdef LSU_MISALIGN_TRAP_EN
    output logic                  misalign_fault,
`endif
    output logic                  Stall
);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_e;

    state_e      state_q;
    logic [2:0]  op_f3_q;
    logic [1:0]  op_off_q;
    logic        op_we_q;

    logic [3:0]  st_strb;
    logic [31:0] st_data;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;
    logic        trap;

    // Store lane steering, computed from the live inputs at acceptance.
    always_comb begin
        st_strb = 4'b1111;
        st_data = WriteData;
        case (funct3[1:0])
            2'b00: begin
                st_strb = 4'b0001 << ALUout[1:0];
                st_data = {4{WriteData[7:0]}};
            end
            2'b01: begin
                st_strb = ALUout[1] ? 4'b1100 : 4'b0011;
                st_data = {2{WriteData[15:0]}};
            end
            default: begin
                st_strb = 4'b1111;
                st_data = WriteData;
            end
        endcase
    end

    // Load extraction, using the offset and width captured at acceptance.
    always_comb begin
        ld_byte = mem_rdata[{op_off_q, 3'b000} +: 8];
        ld_half = op_off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (op_f3_q)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_ext = {24'h0, ld_byte};
            3'b101:  ld_ext = {16'h0, ld_half};
            default: ld_ext = mem_rdata;
        endcase
    end

    // Halfword codes have funct3[1:0]=01; word codes have funct3[1]=1.
`ifdef LSU_MISALIGN_TRAP_EN
    assign trap = ((funct3[1:0] == 2'b01) && ALUout[0]) ||
                  (funct3[1] && (ALUout[1:0] != 2'b00));
`else
    assign trap = 1'b0;
`endif

    assign req_ready = (state_q == StIdle);
    assign Stall     = ((state_q == StIdle) && req_valid) ||
                       (state_q == StReq) || (state_q == StWait);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            op_f3_q   <= 3'b000;
            op_off_q  <= 2'b00;
            op_we_q   <= 1'b0;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wstrb <= 4'b0000;
            mem_wdata <= 32'h0;
            ReadData  <= 32'h0;
            rsp_valid <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            misalign_fault <= 1'b0;
`endif
        end else begin
            rsp_valid <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            misalign_fault <= 1'b0;
`endif
            case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        op_f3_q  <= funct3;
                        op_off_q <= ALUout[1:0];
                        op_we_q  <= MemWrite;
                        if (trap) begin
                            // Completes without a memory access; ReadData untouched.
                            state_q   <= StResp;
                            rsp_valid <= 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
                            misalign_fault <= 1'b1;
`endif
                        end else begin
                            state_q   <= StReq;
                            mem_req   <= 1'b1;
                            mem_addr  <= {ALUout[ADDR_WIDTH-1:2], 2'b00};
                            mem_we    <= MemWrite;
                            mem_wstrb <= MemWrite ? st_strb : 4'b0000;
                            mem_wdata <= MemWrite ? st_data : 32'h0;
                        end
                    end
                end
                StReq: begin
                    if (mem_gnt) begin
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_wstrb <= 4'b0000;
                        if (op_we_q) begin
                            state_q   <= StResp;
                            rsp_valid <= 1'b1;
                        end else begin
                            state_q <= StWait;
                        end
                    end
                end
                StWait: begin
                    if (mem_rvalid) begin
                        ReadData  <= ld_ext;
                        state_q   <= StResp;
                        rsp_valid <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
